// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the queued fetch entry layout.
package fetch_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] ZERO_INSTR  = 32'h00000000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head output holds the last popped
// entry while empty.
module fetch_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [W-1:0]  r_last;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_empty ? r_last : r_mem[r_rd];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_last  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_last <= r_mem[r_rd];
                r_rd   <= r_rd + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, redirect/halt/fault control and the
// decode-facing entry queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int          DEPTH        = 2,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset_L,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        halted,
    output logic        fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [63:0]   r_pc;
    logic          r_halted;
    logic          r_fault;
    logic          w_pop;
    logic          w_push;
    logic          w_can_push;
    logic          w_fetch_en;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_in;
    fetch_entry_t  w_head;

    assign imem_addr  = r_pc;
    assign halted     = r_halted;
    assign fault      = r_fault;
    assign out_valid  = ~w_empty;
    assign out_instr  = w_head.instr;
    assign out_pc     = w_head.pc;
    assign w_pop      = out_valid & out_ready;
    assign w_can_push = (w_count < CW'(DEPTH)) | w_pop;
    assign w_fetch_en = ~r_halted & ~r_fault;
    assign w_push     = ~redirect_valid & w_fetch_en & w_can_push;
    assign w_in       = '{pc: r_pc, instr: imem_data};

    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (Reset_L),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Queue occupancy flags must agree with the counter.
    a_full_consistent: assert property (
        @(posedge CLK) w_full == (w_count == CW'(DEPTH))
    );

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else if (redirect_valid) begin
            if (redirect_target[1:0] == 2'b00) begin
                r_pc     <= redirect_target;
                r_halted <= 1'b0;
            end else begin
                r_fault <= 1'b1;
            end
        end else if (w_push) begin
            r_pc <= r_pc + 64'(INSTR_BYTES);
            if (HALT_ON_ZERO && imem_data == ZERO_INSTR) begin
                r_halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: halt, backpressure, redirect, fault
// and mid-stream reset.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
    logic        fault;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP_W = 32'h8b020020;

    always #5 CLK = ~CLK;

    assign imem_data = (imem_addr <= 64'h10) ? NOP_W : 32'h0;

    fetch_unit #(
        .RESET_PC     (64'h0),
        .DEPTH        (2),
        .HALT_ON_ZERO (1'b1)
    ) u_dut (
        .CLK             (CLK),
        .Reset_L         (Reset_L),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .halted          (halted),
        .fault           (fault)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_L         = 1'b0;
        out_ready       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 64'h0;

        // Reset state, then stream until the zero word halts fetch.
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        Reset_L = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s1_valid", 64'(out_valid), 64'd1);
            chk("s1_pc", out_pc, 64'(4 * i));
            chk("s1_instr", 64'(out_instr), 64'(NOP_W));
        end
        tick();
        chk("s1_zero_pc", out_pc, 64'h14);
        chk("s1_zero_instr", 64'(out_instr), 64'd0);
        chk("s1_halted", 64'(halted), 64'd1);
        chk("s1_halt_addr", imem_addr, 64'h18);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s1_drained", 64'(out_valid), 64'd0);
            chk("s1_hold_addr", imem_addr, 64'h18);
            chk("s1_hold_pc", out_pc, 64'h14);
        end

        // Redirect while halted resumes fetch at the target.
        redirect_valid  = 1'b1;
        redirect_target = 64'h0;
        tick();
        chk("s2_halted", 64'(halted), 64'd0);
        chk("s2_addr", imem_addr, 64'h0);
        chk("s2_valid", 64'(out_valid), 64'd0);
        redirect_valid = 1'b0;
        tick();
        chk("s2_valid1", 64'(out_valid), 64'd1);
        chk("s2_pc0", out_pc, 64'h0);
        tick();
        chk("s2_pc1", out_pc, 64'h4);

        // Backpressure: queue fills, PC and head hold.
        Reset_L   = 1'b0;
        out_ready = 1'b0;
        tick();
        Reset_L = 1'b1;
        tick();
        chk("s3_first", out_pc, 64'h0);
        tick();
        tick();
        chk("s3_count", 64'(u_dut.w_count), 64'd2);
        chk("s3_addr", imem_addr, 64'h8);
        chk("s3_pc", out_pc, 64'h0);
        tick();
        chk("s3_addr_hold", imem_addr, 64'h8);
        chk("s3_pc_hold", out_pc, 64'h0);
        chk("s3_valid_hold", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("s3_order_v", 64'(out_valid), 64'd1);
            chk("s3_order_pc", out_pc, 64'(4 * i));
        end

        // Redirect on a full queue with a pop in the same cycle.
        Reset_L   = 1'b0;
        out_ready = 1'b0;
        tick();
        Reset_L = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        chk("s4_full_pc", out_pc, 64'h4);
        chk("s4_full_cnt", 64'(u_dut.w_count), 64'd2);
        redirect_valid  = 1'b1;
        redirect_target = 64'h8;
        tick();
        chk("s4_flush_v", 64'(out_valid), 64'd0);
        chk("s4_addr", imem_addr, 64'h8);
        redirect_valid = 1'b0;
        tick();
        chk("s4_new_v", 64'(out_valid), 64'd1);
        chk("s4_new_pc", out_pc, 64'h8);
        tick();
        chk("s4_next_pc", out_pc, 64'hC);

        // Misaligned redirect raises a sticky fault.
        redirect_valid  = 1'b1;
        redirect_target = 64'h6;
        tick();
        chk("s5_fault", 64'(fault), 64'd1);
        chk("s5_valid", 64'(out_valid), 64'd0);
        chk("s5_addr", imem_addr, 64'h10);
        redirect_valid = 1'b0;
        tick();
        chk("s5_valid2", 64'(out_valid), 64'd0);
        redirect_valid  = 1'b1;
        redirect_target = 64'h0;
        tick();
        chk("s5_still", 64'(fault), 64'd1);
        chk("s5_addr0", imem_addr, 64'h0);
        redirect_valid = 1'b0;
        tick();
        chk("s5_valid3", 64'(out_valid), 64'd0);
        chk("s5_still2", 64'(fault), 64'd1);
        Reset_L = 1'b0;
        tick();
        chk("s5_clear", 64'(fault), 64'd0);
        Reset_L = 1'b1;

        // Reset mid-stream discards queued entries.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s6_pc", out_pc, 64'(4 * i));
        end
        chk("s6_valid", 64'(out_valid), 64'd1);
        Reset_L = 1'b0;
        tick();
        chk("s6_rst_v", 64'(out_valid), 64'd0);
        chk("s6_rst_addr", imem_addr, 64'h0);
        chk("s6_rst_halt", 64'(halted), 64'd0);
        chk("s6_rst_fault", 64'(fault), 64'd0);
        Reset_L = 1'b1;
        tick();
        chk("s6_restart_v", 64'(out_valid), 64'd1);
        chk("s6_restart_pc", out_pc, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
